// File: rtl/tag_comparator_pkg.sv
// Shared defaults and helpers for the data-cache tag comparator.
package tag_comparator_pkg;

    localparam int TAG_W_DEF = 3;
    localparam int WAYS_DEF  = 1;
    localparam int CNT_W_DEF = 16;

    // Way-index width; a single-way cache still carries a 1-bit index.
    function automatic int way_idx_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/tag_cmp_prio_enc.sv
// Lowest-index-first priority encoder with any-set and more-than-one-set flags.
module tag_cmp_prio_enc #(
    parameter int N     = 1,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
    end

    assign any = |req;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/tag_comparator.sv
// Data-cache tag comparator: combinational match/hit, registered hit copies and
// optional hit/miss statistics counters (built when TAG_COMPARATOR_STATS_EN is defined).
module tag_comparator
    import tag_comparator_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int WAYS  = WAYS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [TAG_W-1:0]              req_tag,
    input  logic [WAYS*TAG_W-1:0]         stored_tag,
    input  logic [WAYS-1:0]               stored_valid,
    input  logic                          compare_en,
    output logic [WAYS-1:0]               match,
    output logic                          hit,
    output logic [way_idx_w(WAYS)-1:0]    hit_way,
    output logic                          multi_hit,
    output logic                          hit_q,
    output logic [way_idx_w(WAYS)-1:0]    hit_way_q,
    output logic [CNT_W-1:0]              hit_count,
    output logic [CNT_W-1:0]              miss_count
);

    localparam int IDX_W = way_idx_w(WAYS);

    logic [WAYS-1:0]  way_hit;
    logic [IDX_W-1:0] enc_idx;
    logic             any_hit;
    logic             multi_raw;

    always_comb begin
        match = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = (stored_tag[w*TAG_W +: TAG_W] == req_tag);
        end
    end

    assign way_hit = match & stored_valid;

    tag_cmp_prio_enc #(
        .N     (WAYS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (way_hit),
        .idx   (enc_idx),
        .any   (any_hit),
        .multi (multi_raw)
    );

    assign hit       = compare_en & any_hit;
    assign hit_way   = hit ? enc_idx : '0;
    assign multi_hit = compare_en & multi_raw;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_q     <= 1'b0;
            hit_way_q <= '0;
        end else begin
            hit_q     <= hit;
            hit_way_q <= hit_way;
        end
    end

`ifdef TAG_COMPARATOR_STATS_EN
    // Saturating counters: a pegged counter stays at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (compare_en) begin
            if (hit) begin
                if (hit_count != {CNT_W{1'b1}}) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
            end else begin
                if (miss_count != {CNT_W{1'b1}}) begin
                    miss_count <= miss_count + CNT_W'(1);
                end
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_tag_comparator.sv
// Bench for tag_comparator: a 1-way and a 4-way (2-bit counter) instance checked
// against a behavioural model every cycle, plus directed literal expectations.
module tb_tag_comparator;

    localparam int MAX1 = 65535;
    localparam int MAX4 = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic [2:0]  r1_tag = '0, s1_tag = '0;
    logic        v1 = 1'b0, en1 = 1'b0;
    logic [2:0]  r4_tag = '0;
    logic [11:0] s4_tag = '0;
    logic [3:0]  v4 = '0;
    logic        en4 = 1'b0;

    logic        w1_match, w1_hit, w1_hw, w1_mh, w1_hq, w1_hwq;
    logic [15:0] w1_hc, w1_mc;
    logic [3:0]  w4_match;
    logic        w4_hit, w4_mh, w4_hq;
    logic [1:0]  w4_hw, w4_hwq;
    logic [1:0]  w4_hc, w4_mc;

    int checks   = 0;
    int failures = 0;

    // Model state for the registered outputs and counters.
    logic m1_hq = 1'b0, m4_hq = 1'b0;
    int   m1_hwq = 0, m4_hwq = 0;
    int   m1_hc = 0, m1_mc = 0, m4_hc = 0, m4_mc = 0;

    tag_comparator #(.TAG_W(3), .WAYS(1), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .req_tag(r1_tag), .stored_tag(s1_tag),
        .stored_valid(v1), .compare_en(en1), .match(w1_match), .hit(w1_hit),
        .hit_way(w1_hw), .multi_hit(w1_mh), .hit_q(w1_hq), .hit_way_q(w1_hwq),
        .hit_count(w1_hc), .miss_count(w1_mc)
    );

    tag_comparator #(.TAG_W(3), .WAYS(4), .CNT_W(2)) dut4 (
        .clock(clock), .reset(reset), .req_tag(r4_tag), .stored_tag(s4_tag),
        .stored_valid(v4), .compare_en(en4), .match(w4_match), .hit(w4_hit),
        .hit_way(w4_hw), .multi_hit(w4_mh), .hit_q(w4_hq), .hit_way_q(w4_hwq),
        .hit_count(w4_hc), .miss_count(w4_mc)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- model ----------------
    function automatic void model(input int ways, input logic [2:0] rt,
                                  input logic [11:0] st, input logic [3:0] sv,
                                  input logic en, output logic [3:0] m,
                                  output logic h, output int hw, output logic mh);
        int n;
        m  = '0;
        hw = 0;
        n  = 0;
        for (int w = 0; w < ways; w++) begin
            m[w] = (st[w*3 +: 3] == rt);
            if (m[w] && sv[w]) begin
                if (n == 0) hw = w;
                n++;
            end
        end
        h  = en && (n > 0);
        mh = en && (n > 1);
        if (!h) hw = 0;
    endfunction

    logic [3:0] u_m1, u_m4;
    logic       u_h1, u_h4, u_mh1, u_mh4;
    int         u_hw1, u_hw4;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m1_hq <= 1'b0; m1_hwq <= 0; m1_hc <= 0; m1_mc <= 0;
            m4_hq <= 1'b0; m4_hwq <= 0; m4_hc <= 0; m4_mc <= 0;
        end else begin
            model(1, r1_tag, {9'b0, s1_tag}, {3'b0, v1}, en1, u_m1, u_h1, u_hw1, u_mh1);
            model(4, r4_tag, s4_tag, v4, en4, u_m4, u_h4, u_hw4, u_mh4);
            m1_hq  <= u_h1;
            m1_hwq <= u_hw1;
            m4_hq  <= u_h4;
            m4_hwq <= u_hw4;
            if (en1) begin
                if (u_h1) m1_hc <= (m1_hc == MAX1) ? m1_hc : m1_hc + 1;
                else      m1_mc <= (m1_mc == MAX1) ? m1_mc : m1_mc + 1;
            end
            if (en4) begin
                if (u_h4) m4_hc <= (m4_hc == MAX4) ? m4_hc : m4_hc + 1;
                else      m4_mc <= (m4_mc == MAX4) ? m4_mc : m4_mc + 1;
            end
        end
    end

    function automatic int stat_exp(input int v);
`ifdef TAG_COMPARATOR_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [3:0] c_m1, c_m4;
    logic       c_h1, c_h4, c_mh1, c_mh4;
    int         c_hw1, c_hw4;

    always @(negedge clock) begin
        model(1, r1_tag, {9'b0, s1_tag}, {3'b0, v1}, en1, c_m1, c_h1, c_hw1, c_mh1);
        model(4, r4_tag, s4_tag, v4, en4, c_m4, c_h4, c_hw4, c_mh4);
        chk("w1_match", 32'(w1_match), 32'(c_m1[0]));
        chk("w1_hit",   32'(w1_hit),   32'(c_h1));
        chk("w1_hitway", 32'(w1_hw),   32'(c_hw1));
        chk("w1_multi", 32'(w1_mh),    32'(c_mh1));
        chk("w1_hit_q", 32'(w1_hq),    32'(m1_hq));
        chk("w1_hitway_q", 32'(w1_hwq), 32'(m1_hwq));
        chk("w1_hit_count", 32'(w1_hc), 32'(stat_exp(m1_hc)));
        chk("w1_miss_count", 32'(w1_mc), 32'(stat_exp(m1_mc)));
        chk("w4_match", 32'(w4_match), 32'(c_m4));
        chk("w4_hit",   32'(w4_hit),   32'(c_h4));
        chk("w4_hitway", 32'(w4_hw),   32'(c_hw4));
        chk("w4_multi", 32'(w4_mh),    32'(c_mh4));
        chk("w4_hit_q", 32'(w4_hq),    32'(m4_hq));
        chk("w4_hitway_q", 32'(w4_hwq), 32'(m4_hwq));
        chk("w4_hit_count", 32'(w4_hc), 32'(stat_exp(m4_hc)));
        chk("w4_miss_count", 32'(w4_mc), 32'(stat_exp(m4_mc)));
    end

    // ---------------- driver tasks ----------------
    task automatic drive1(input logic [2:0] rt, input logic [2:0] st,
                          input logic v, input logic en);
        r1_tag = rt; s1_tag = st; v1 = v; en1 = en;
    endtask

    task automatic drive4(input logic [2:0] rt, input logic [11:0] st,
                          input logic [3:0] v, input logic en);
        r4_tag = rt; s4_tag = st; v4 = v; en4 = en;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Stored tags {6,2,6,1} for ways 3..0.
    localparam logic [11:0] TAGS_6261 = {3'd6, 3'd2, 3'd6, 3'd1};

    // ---------------- directed stimulus ----------------
    initial begin
        step();
        step();
        chk("rst_w1_hit_q", 32'(w1_hq), 32'd0);
        chk("rst_w4_hitway_q", 32'(w4_hwq), 32'd0);
        chk("rst_w1_hit_count", 32'(w1_hc), 32'd0);
        @(negedge clock); #1;
        reset = 1'b1;

        // 1-way: tag match with valid
        drive1(3'b101, 3'b101, 1'b1, 1'b1);
        #1;
        chk("v1_match", 32'(w1_match), 32'd1);
        chk("v1_hit", 32'(w1_hit), 32'd1);
        chk("v1_hitway", 32'(w1_hw), 32'd0);
        step();
        chk("v1_hit_q", 32'(w1_hq), 32'd1);

        // match ignores valid; mismatch never hits
        drive1(3'b101, 3'b101, 1'b0, 1'b1);
        #1;
        chk("v2_match", 32'(w1_match), 32'd1);
        chk("v2_hit", 32'(w1_hit), 32'd0);
        step();
        drive1(3'b101, 3'b100, 1'b1, 1'b1);
        #1;
        chk("v3_match", 32'(w1_match), 32'd0);
        chk("v3_hit", 32'(w1_hit), 32'd0);
        step();

        // 4-way: two valid hits, lowest wins
        drive1(3'b000, 3'b111, 1'b0, 1'b0);
        drive4(3'd6, TAGS_6261, 4'b1111, 1'b1);
        #1;
        chk("w4a_match", 32'(w4_match), 32'b1010);
        chk("w4a_hit", 32'(w4_hit), 32'd1);
        chk("w4a_hitway", 32'(w4_hw), 32'd1);
        chk("w4a_multi", 32'(w4_mh), 32'd1);
        step();
        drive4(3'd6, TAGS_6261, 4'b1101, 1'b1);
        #1;
        chk("w4b_hitway", 32'(w4_hw), 32'd3);
        chk("w4b_multi", 32'(w4_mh), 32'd0);
        drive4(3'd6, TAGS_6261, 4'b1101, 1'b0);
        #1;
        chk("w4c_gated_hit", 32'(w4_hit), 32'd0);
        chk("w4c_gated_hitway", 32'(w4_hw), 32'd0);
        chk("w4c_match_ungated", 32'(w4_match), 32'b1010);
        drive4(3'd6, TAGS_6261, 4'b1101, 1'b1);
        step();

        // asynchronous reset between edges
        drive1(3'b101, 3'b101, 1'b1, 1'b1);
        step();
        chk("pre_rst_w1_hit_q", 32'(w1_hq), 32'd1);
        chk("pre_rst_w4_hitway_q", 32'(w4_hwq), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("async_w1_hit_q", 32'(w1_hq), 32'd0);
        chk("async_w4_hit_q", 32'(w4_hq), 32'd0);
        chk("async_w4_hitway_q", 32'(w4_hwq), 32'd0);
        chk("async_w4_hit_count", 32'(w4_hc), 32'd0);
        chk("async_comb_hit", 32'(w1_hit), 32'd1);
        @(negedge clock); #1;
        reset = 1'b1;
        step();
        chk("recap_w1_hit_q", 32'(w1_hq), 32'd1);
        chk("recap_w4_hitway_q", 32'(w4_hwq), 32'd3);

        // statistics: clear, then 3 hit / 2 miss / 1 idle on w1, 5 hits on w4
        drive1(3'b101, 3'b101, 1'b1, 1'b0);
        drive4(3'd6, TAGS_6261, 4'b1101, 1'b0);
        reset = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1;
        drive1(3'b101, 3'b101, 1'b1, 1'b1); drive4(3'd6, TAGS_6261, 4'b1101, 1'b1); step();
        drive1(3'b101, 3'b101, 1'b1, 1'b1); step();
        drive1(3'b101, 3'b100, 1'b1, 1'b1); step();
        drive1(3'b101, 3'b100, 1'b1, 1'b0); drive4(3'd6, TAGS_6261, 4'b1101, 1'b0); step();
        drive1(3'b101, 3'b101, 1'b1, 1'b1); drive4(3'd6, TAGS_6261, 4'b1101, 1'b1); step();
        drive1(3'b010, 3'b101, 1'b1, 1'b1); step();
        drive1(3'b010, 3'b101, 1'b1, 1'b0);
        drive4(3'd6, TAGS_6261, 4'b1101, 1'b0);
        #1;
`ifdef TAG_COMPARATOR_STATS_EN
        chk("stat_w1_hit_count", 32'(w1_hc), 32'd3);
        chk("stat_w1_miss_count", 32'(w1_mc), 32'd2);
        chk("stat_w4_hit_sat", 32'(w4_hc), 32'd3);
        chk("stat_w4_miss_count", 32'(w4_mc), 32'd0);
`else
        chk("stat_w1_hit_count", 32'(w1_hc), 32'd0);
        chk("stat_w1_miss_count", 32'(w1_mc), 32'd0);
        chk("stat_w4_hit_count", 32'(w4_hc), 32'd0);
        chk("stat_w4_miss_count", 32'(w4_mc), 32'd0);
`endif
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
